// File: rtl/seq_ctrl_pkg.sv
// Shared types and default sizes for the serial sequence detector.
// The timeout feature is compiled in with SEQ_CTRL_TIMEOUT_EN.
package seq_ctrl_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_TO_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A run needs at least one pattern bit and no more than the shifter holds.
    function automatic logic len_is_legal(input logic [3:0] len, input int pat_w);
        return (len != 4'd0) && (int'(len) <= pat_w);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial shift register, received-bit count and masked pattern comparator.
// hit is combinational: it reflects the register contents after the current bit.
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       pat_len,
    output logic             hit
);

    localparam int RXW = ($clog2(PAT_W + 1) > 4) ? $clog2(PAT_W + 1) : 4;

    logic [PAT_W-1:0] shift_reg;
    logic [PAT_W-1:0] shift_next;
    logic [PAT_W-1:0] len_mask;
    logic [RXW-1:0]   rx_cnt_reg;
    logic [RXW-1:0]   rx_cnt_next;
    logic             enough;
    logic             equal;

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
            assign len_mask[gi] = (gi < int'(pat_len));
        end
    endgenerate

    assign shift_next = {shift_reg[PAT_W-2:0], bit_in};

    // The count saturates at PAT_W; beyond that every legal length is satisfied.
    assign rx_cnt_next = (rx_cnt_reg < RXW'(PAT_W)) ? rx_cnt_reg + RXW'(1) : rx_cnt_reg;
    assign enough      = (rx_cnt_next >= RXW'(pat_len));
    assign equal       = (((shift_next ^ pattern) & len_mask) == '0);
    assign hit         = shift_en & enough & equal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            rx_cnt_reg <= '0;
        end else if (clear) begin
            shift_reg  <= '0;
            rx_cnt_reg <= '0;
        end else if (shift_en) begin
            shift_reg  <= shift_next;
            // Non-overlapping mode: the next match must be built from fresh bits.
            rx_cnt_reg <= (hit && !overlap) ? '0 : rx_cnt_next;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial sequence detector: start/abort handshake,
// match counting and completion. Define SEQ_CTRL_TIMEOUT_EN for the idle-bit timeout.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TO_W  = DEF_TO_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [3:0]       i_pat_len,
    input  logic [CNT_W-1:0] i_target,
    input  logic             i_overlap,
    input  logic [TO_W-1:0]  i_timeout_lim,
    input  logic             i_bit_valid,
    input  logic             i_bit,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_match,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic             o_done,
    output logic             o_timeout
);

    state_t           state_reg;
    logic [PAT_W-1:0] pattern_reg;
    logic [3:0]       pat_len_reg;
    logic [CNT_W-1:0] target_reg;
    logic             overlap_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_inc;
    logic             busy_reg;
    logic             match_reg;
    logic             done_reg;
    logic             timeout_reg;

    logic start_ok;
    logic core_clear;
    logic shift_en;
    logic hit;
    logic target_hit;
    logic to_expire;

    assign start_ok   = i_start && len_is_legal(i_pat_len, PAT_W);
    assign core_clear = (state_reg == ST_ARM);
    // An abort suppresses the bit entirely, so a simultaneous match never counts.
    assign shift_en   = (state_reg == ST_RUN) && i_bit_valid && !i_abort;
    assign cnt_inc    = cnt_reg + CNT_W'(1);
    assign target_hit = (cnt_inc == target_reg);

    seq_match_core #(
        .PAT_W(PAT_W)
    ) u_core (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (core_clear),
        .shift_en(shift_en),
        .bit_in  (i_bit),
        .overlap (overlap_reg),
        .pattern (pattern_reg),
        .pat_len (pat_len_reg),
        .hit     (hit)
    );

`ifdef SEQ_CTRL_TIMEOUT_EN
    logic [TO_W-1:0] to_lim_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic [TO_W-1:0] to_cnt_inc;

    assign to_cnt_inc = to_cnt_reg + TO_W'(1);
    // A zero limit disables the timeout.
    assign to_expire  = (to_lim_reg != '0) && (to_cnt_inc == to_lim_reg);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_lim_reg <= '0;
            to_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE && start_ok) begin
            to_lim_reg <= i_timeout_lim;
        end else if (state_reg == ST_ARM) begin
            to_cnt_reg <= '0;
        end else if (shift_en) begin
            to_cnt_reg <= hit ? '0 : to_cnt_inc;
        end
    end
`else
    logic unused_timeout_lim;

    assign to_expire          = 1'b0;
    assign unused_timeout_lim = ^i_timeout_lim;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            pattern_reg <= '0;
            pat_len_reg <= '0;
            target_reg  <= '0;
            overlap_reg <= 1'b0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            match_reg   <= 1'b0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            match_reg   <= 1'b0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        pattern_reg <= i_pattern;
                        pat_len_reg <= i_pat_len;
                        target_reg  <= i_target;
                        overlap_reg <= i_overlap;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    cnt_reg <= '0;
                    if (i_abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (target_reg == '0) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_DONE;
                    end else begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (hit) begin
                        match_reg <= 1'b1;
                        cnt_reg   <= cnt_inc;
                        // Leaving RUN at the target is what keeps the count from wrapping.
                        if (target_hit) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_DONE;
                        end
                    end else if (shift_en && to_expire) begin
                        timeout_reg <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = busy_reg;
    assign o_match     = match_reg;
    assign o_match_cnt = cnt_reg;
    assign o_done      = done_reg;
    assign o_timeout   = timeout_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: a bit-history model predicts each output
// event, a negedge monitor consumes them. Honours SEQ_CTRL_TIMEOUT_EN if defined.
module tb_seq_detect_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_pattern = '0;
    logic [3:0]  i_pat_len = '0;
    logic [7:0]  i_target = '0;
    logic        i_overlap = 1'b0;
    logic [15:0] i_timeout_lim = '0;
    logic        i_bit_valid = 1'b0;
    logic        i_bit = 1'b0;
    logic        i_abort = 1'b0;
    logic        o_busy;
    logic        o_match;
    logic [7:0]  o_match_cnt;
    logic        o_done;
    logic        o_timeout;

    seq_detect_ctrl #(
        .PAT_W(8),
        .CNT_W(8),
        .TO_W (16)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_pattern    (i_pattern),
        .i_pat_len    (i_pat_len),
        .i_target     (i_target),
        .i_overlap    (i_overlap),
        .i_timeout_lim(i_timeout_lim),
        .i_bit_valid  (i_bit_valid),
        .i_bit        (i_bit),
        .i_abort      (i_abort),
        .o_busy       (o_busy),
        .o_match      (o_match),
        .o_match_cnt  (o_match_cnt),
        .o_done       (o_done),
        .o_timeout    (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       m;
        logic       d;
        logic       t;
        logic [7:0] cnt;
        int         cyc;
    } ev_t;

    ev_t sb[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(input logic m, input logic d, input logic t,
                                    input int cnt, input int at_cyc);
        ev_t e;
        e.m   = m;
        e.d   = d;
        e.t   = t;
        e.cnt = 8'(cnt);
        e.cyc = at_cyc;
        sb.push_back(e);
    endfunction

    // Monitor: every pulse on the outputs must match the next predicted event.
    always @(negedge i_clk) begin
        ev_t e;
        if (!i_rst && (o_match || o_done || o_timeout)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_event: got m=%0b d=%0b t=%0b cnt=%0d at cycle %0d, expected no event",
                         o_match, o_done, o_timeout, o_match_cnt, cyc);
            end else begin
                e = sb.pop_front();
                check("event_kind", {29'd0, o_match, o_done, o_timeout}, {29'd0, e.m, e.d, e.t});
                check("event_cnt", {24'd0, o_match_cnt}, {24'd0, e.cnt});
                check("event_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic quiet();
        i_start     = 1'b0;
        i_bit_valid = 1'b0;
        i_bit       = 1'b0;
        i_abort     = 1'b0;
    endtask

    // Scramble start/config inputs; the DUT must ignore them outside IDLE.
    task automatic noise_cfg(input bit en);
        if (en) begin
            i_start       = 1'($urandom);
            i_pattern     = 8'($urandom);
            i_pat_len     = 4'($urandom);
            i_target      = 8'($urandom);
            i_overlap     = 1'($urandom);
            i_timeout_lim = 16'($urandom_range(1, 3));
        end
    endtask

    // One detection run: start, feed bits, predict events from the bit history.
    // kind: 0 bits exhausted (aborted by the bench), 1 done, 2 timeout, 3 abort.
    task automatic run(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt,
                       input logic ovl, input logic [15:0] lim, input int nbits,
                       input logic [63:0] bits, input int abort_at, input int gap_pct,
                       input bit noisy);
        logic hist[$];
        int   mcnt = 0;
        int   tocnt = 0;
        int   kind = 0;
        bit   legal;
        bit   hitm;
        legal         = (len >= 4'd1) && (len <= 4'd8);
        i_pattern     = pat;
        i_pat_len     = len;
        i_target      = tgt;
        i_overlap     = ovl;
        i_timeout_lim = lim;
        i_start       = 1'b1;
        tick();
        i_start = 1'b0;
        if (!legal) begin
            check("illegal_len_busy", {31'd0, o_busy}, 32'd0);
            tick();
            check("illegal_len_busy_hold", {31'd0, o_busy}, 32'd0);
        end else begin
            check("arm_busy", {31'd0, o_busy}, 32'd1);
            noise_cfg(noisy);
            i_bit_valid = 1'($urandom);
            i_bit       = 1'($urandom);
            if (tgt == 8'd0) begin
                push_ev(1'b0, 1'b1, 1'b0, 0, cyc + 1);
                tick();
                quiet();
                check("zero_tgt_busy", {31'd0, o_busy}, 32'd0);
                tick();
                kind = 1;
            end else begin
                tick();
                for (int i = 0; i < nbits && kind == 0; i++) begin
                    while ($urandom_range(99) < gap_pct) begin
                        noise_cfg(noisy);
                        i_bit_valid = 1'b0;
                        i_bit       = 1'($urandom);
                        tick();
                    end
                    noise_cfg(noisy);
                    i_bit_valid = 1'b1;
                    i_bit       = bits[i];
                    if (i == abort_at) begin
                        i_abort = 1'b1;
                        kind    = 3;
                    end else begin
                        hist.push_back(bits[i]);
                        hitm = (hist.size() >= int'(len));
                        for (int j = 0; j < int'(len) && hitm; j++)
                            if (hist[hist.size() - 1 - j] != pat[j]) hitm = 1'b0;
                        if (hitm) begin
                            mcnt++;
                            tocnt = 0;
                            if (!ovl) hist.delete();
                            push_ev(1'b1, mcnt == int'(tgt), 1'b0, mcnt, cyc + 1);
                            if (mcnt == int'(tgt)) kind = 1;
                        end else begin
                            tocnt++;
`ifdef SEQ_CTRL_TIMEOUT_EN
                            if (lim != 16'd0 && tocnt == int'(lim)) begin
                                push_ev(1'b0, 1'b0, 1'b1, mcnt, cyc + 1);
                                kind = 2;
                            end
`endif
                        end
                    end
                    tick();
                end
                quiet();
                if (kind == 0) begin
                    check("run_busy", {31'd0, o_busy}, 32'd1);
                    i_abort = 1'b1;
                    tick();
                    i_abort = 1'b0;
                end else if (kind == 1) begin
                    tick();
                end
                check("end_idle_busy", {31'd0, o_busy}, 32'd0);
            end
            check("end_cnt", {24'd0, o_match_cnt}, 32'(mcnt));
        end
        tick();
        tick();
        check("sb_drained", sb.size(), 32'd0);
        sb.delete();
        $display("run pat=%b len=%0d tgt=%0d ovl=%0b lim=%0d bits=%0d matches=%0d end=%0d",
                 pat, len, tgt, ovl, lim, nbits, mcnt, kind);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_match", {31'd0, o_match}, 32'd0);
        check("rst_cnt", {24'd0, o_match_cnt}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_timeout", {31'd0, o_timeout}, 32'd0);
        i_rst = 1'b0;
        tick();

        // Directed scenarios.
        run(8'b110, 4'd3, 8'd2, 1'b0, 16'd0, 6, 64'b011011, -1, 0, 1'b0);
        run(8'b11, 4'd2, 8'd5, 1'b1, 16'd0, 3, 64'b111, -1, 0, 1'b0);
        run(8'b11, 4'd2, 8'd5, 1'b0, 16'd0, 3, 64'b111, -1, 0, 1'b0);
        run(8'b101, 4'd3, 8'd0, 1'b0, 16'd0, 0, 64'd0, -1, 0, 1'b0);
        run(8'b110, 4'd3, 8'd2, 1'b0, 16'd0, 6, 64'b011011, 5, 0, 1'b0);
        run(8'b110, 4'd0, 8'd2, 1'b0, 16'd0, 6, 64'b011011, -1, 0, 1'b0);
        run(8'b110, 4'd9, 8'd2, 1'b0, 16'd0, 6, 64'b011011, -1, 0, 1'b0);
        run(8'b110, 4'd3, 8'd2, 1'b0, 16'd0, 6, 64'b011011, -1, 30, 1'b1);
        run(8'b111, 4'd3, 8'd2, 1'b0, 16'd4, 4, 64'd0, -1, 0, 1'b0);
        run(8'b1, 4'd1, 8'd3, 1'b0, 16'd0, 5, 64'b10101, -1, 0, 1'b0);
        run(8'hA5, 4'd8, 8'd2, 1'b1, 16'd0, 24, 64'hA5_A5A5, -1, 10, 1'b1);

        // Reset in the middle of a run discards it silently.
        i_pattern = 8'd1;
        i_pat_len = 4'd1;
        i_target  = 8'd200;
        i_overlap = 1'b0;
        i_start   = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            i_bit_valid = 1'b1;
            i_bit       = 1'b1;
            push_ev(1'b1, 1'b0, 1'b0, k + 1, cyc + 1);
            tick();
        end
        quiet();
        tick();
        tick();
        check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        check("pre_rst_cnt", {24'd0, o_match_cnt}, 32'd4);
        i_rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_cnt", {24'd0, o_match_cnt}, 32'd0);
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        tick();
        check("post_rst_busy", {31'd0, o_busy}, 32'd0);
        check("post_rst_sb", sb.size(), 32'd0);
        $display("reset mid-run applied");

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            logic [3:0]  len;
            logic [63:0] bits;
            int          nb;
            int          ab;
            len  = ($urandom_range(9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(1, 8));
            if ($urandom_range(19) == 0) len = 4'd0;
            bits = {$urandom, $urandom};
            nb   = $urandom_range(10, 48);
            ab   = ($urandom_range(4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            run(8'($urandom), len, 8'($urandom_range(0, 6)), 1'($urandom),
                ($urandom_range(1) == 0) ? 16'd0 : 16'($urandom_range(2, 10)),
                nb, bits, ab, 20, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
